// File: rtl/mcpu_alu_pkg.sv
// Shared definitions for the MCPU ALU execution unit.
// Opcode map and the default-size response bundle.
package mcpu_alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    localparam int DEF_WORD_SIZE = 8;
    localparam int DEF_TAG_SIZE  = 4;

    typedef struct packed {
        logic [DEF_WORD_SIZE-1:0] out;
        logic                     overflow;
        logic [DEF_TAG_SIZE-1:0]  tag;
    } alu_rsp_t;

endpackage

// File: rtl/mcpu_rsp_fifo.sv
// In-order response FIFO with cleared storage on reset.
// Caller guarantees no push when full and no pop when empty.
module mcpu_rsp_fifo
    import mcpu_alu_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage, pointers and occupancy; pointers wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/mcpu_alu_unit.sv
// Handshaked, registered MCPU ALU with an in-order tagged
// response FIFO guarded by credit-based request flow control.
module mcpu_alu_unit
    import mcpu_alu_pkg::*;
#(
    parameter int CMD_SIZE   = 2,
    parameter int WORD_SIZE  = 8,
    parameter int TAG_SIZE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CMD_SIZE-1:0]  req_opcode,
    input  logic [WORD_SIZE-1:0] req_r1,
    input  logic [WORD_SIZE-1:0] req_r2,
    input  logic [TAG_SIZE-1:0]  req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_out,
    output logic                 rsp_overflow,
    output logic [TAG_SIZE-1:0]  rsp_tag,
    output logic                 busy,
    output logic [7:0]           ovf_count
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int RSP_W = WORD_SIZE + 1 + TAG_SIZE;

    typedef struct packed {
        logic [WORD_SIZE-1:0] out;
        logic                 overflow;
        logic [TAG_SIZE-1:0]  tag;
    } rsp_t;

    logic                 r_stage_valid;
    logic [CMD_SIZE-1:0]  r_op;
    logic [WORD_SIZE-1:0] r_r1;
    logic [WORD_SIZE-1:0] r_r2;
    logic [TAG_SIZE-1:0]  r_tag;
    logic [7:0]           r_ovf_count;

    logic                 w_accept;
    logic                 w_pop;
    logic [CW-1:0]        w_fifo_count;
    logic [CW:0]          w_credit;
    logic [WORD_SIZE-1:0] w_sum;
    logic [WORD_SIZE-1:0] w_res;
    logic                 w_ovf;
    rsp_t                 w_wdata;
    rsp_t                 w_head;

    // Entries in flight (stage + FIFO) must stay below depth to accept.
    assign w_credit  = {1'b0, w_fifo_count}
                     + {{CW{1'b0}}, r_stage_valid};
    assign req_ready = w_credit < (CW+1)'(FIFO_DEPTH);
    assign w_accept  = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    // Stage register: capture accepted request, drains every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage_valid <= 1'b0;
            r_op          <= '0;
            r_r1          <= '0;
            r_r2          <= '0;
            r_tag         <= '0;
        end else begin
            r_stage_valid <= w_accept;
            if (w_accept) begin
                r_op  <= req_opcode;
                r_r1  <= req_r1;
                r_r2  <= req_r2;
                r_tag <= req_tag;
            end
        end
    end

    // ALU result and signed overflow from the stage register.
    always_comb begin
        w_sum = r_r1 + r_r2;
        w_res = '0;
        w_ovf = 1'b0;
        unique case (r_op)
            OP_AND: w_res = r_r1 & r_r2;
            OP_OR:  w_res = r_r1 | r_r2;
            OP_XOR: w_res = r_r1 ^ r_r2;
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (r_r1[WORD_SIZE-1] == r_r2[WORD_SIZE-1])
                     && (w_sum[WORD_SIZE-1] != r_r1[WORD_SIZE-1]);
            end
        endcase
    end

    assign w_wdata = '{out: w_res, overflow: w_ovf, tag: r_tag};

    mcpu_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_stage_valid),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

    // Saturating count of overflowed responses handed downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_count <= '0;
        end else if (w_pop && w_head.overflow && r_ovf_count != 8'hFF) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign rsp_valid    = w_fifo_count != '0;
    assign rsp_out      = w_head.out;
    assign rsp_overflow = w_head.overflow;
    assign rsp_tag      = w_head.tag;
    assign busy         = r_stage_valid || rsp_valid;
    assign ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_mcpu_alu_unit.sv
// Self-checking bench for mcpu_alu_unit: directed scenarios plus
// randomized traffic against an arithmetic reference queue model.
module tb_mcpu_alu_unit;
    import mcpu_alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_opcode = '0;
    logic [7:0] req_r1 = '0;
    logic [7:0] req_r2 = '0;
    logic [3:0] req_tag = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_out;
    logic       rsp_overflow;
    logic [3:0] rsp_tag;
    logic       busy;
    logic [7:0] ovf_count;

    mcpu_alu_unit #(
        .CMD_SIZE   (2),
        .WORD_SIZE  (8),
        .TAG_SIZE   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_r1       (req_r1),
        .req_r2       (req_r2),
        .req_tag      (req_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_out      (rsp_out),
        .rsp_overflow (rsp_overflow),
        .rsp_tag      (rsp_tag),
        .busy         (busy),
        .ovf_count    (ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_rsp_t rsp;
        int       vis;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;
    int   m_ovf   = 0;
    int   n_pop   = 0;
    bit   last_acc;

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference ALU written from the arithmetic definition.
    function automatic alu_rsp_t ref_alu(int op, int a, int b, int tag);
        alu_rsp_t r;
        int s, sa, sb;
        r.tag = 4'(tag);
        r.overflow = 1'b0;
        case (op)
            0: r.out = 8'(a & b);
            1: r.out = 8'(a | b);
            2: r.out = 8'(a ^ b);
            default: begin
                s = (a + b) % 256;
                r.out = 8'(s);
                sa = (a > 127) ? a - 256 : a;
                sb = (b > 127) ? b - 256 : b;
                r.overflow = (sa + sb > 127) || (sa + sb < -128);
            end
        endcase
        return r;
    endfunction

    task automatic check_all();
        bit ev;
        ev = 1'b0;
        if (q.size() > 0) ev = (edge_n >= q[0].vis);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_out", rsp_out, q[0].rsp.out);
            chk("rsp_overflow", rsp_overflow, q[0].rsp.overflow);
            chk("rsp_tag", rsp_tag, q[0].rsp.tag);
        end
        chk("busy", busy, q.size() != 0);
        chk("req_ready", req_ready, q.size() < 4);
        chk("ovf_count", ovf_count, m_ovf);
    endtask

    // Advance one clock, updating the model with the handshakes
    // that occur at that edge, then check outputs at the negedge.
    task automatic step();
        bit acc, pop;
        exp_t e;
        acc = !reset && req_valid && req_ready;
        pop = !reset && rsp_valid && rsp_ready;
        if (reset) begin
            q.delete();
            m_ovf = 0;
        end else begin
            if (pop && q.size() > 0) begin
                if (q[0].rsp.overflow && m_ovf < 255) m_ovf++;
                void'(q.pop_front());
                n_pop++;
            end
            if (acc) begin
                e.rsp = ref_alu(req_opcode, req_r1, req_r2, req_tag);
                e.vis = edge_n + 2;
                q.push_back(e);
            end
        end
        last_acc = acc;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(bit v, int op, int a, int b, int t);
        req_valid  = v;
        req_opcode = 2'(op);
        req_r1     = 8'(a);
        req_r2     = 8'(b);
        req_tag    = 4'(t);
    endtask

    task automatic xchk(string name, int o, int v, int t);
        chk({name, "_valid"}, rsp_valid, 1);
        chk({name, "_out"}, rsp_out, o);
        chk({name, "_ovf"}, rsp_overflow, v);
        chk({name, "_tag"}, rsp_tag, t);
    endtask

    task automatic drain(string name, int limit);
        int k;
        k = 0;
        while ((q.size() > 0 || busy) && k < limit) begin
            step();
            k++;
        end
        chk({name, "_drained"}, busy, 0);
    endtask

    initial begin
        int n, a, b, op, t;
        bit pend;

        // Reset
        @(negedge clk);
        step();
        step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf_count", ovf_count, 0);
        chk("rst_rsp_out", rsp_out, 0);
        chk("rst_rsp_ovf", rsp_overflow, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        reset = 1'b0;

        // Logic ops and plain add, back to back
        drive(1, 0, 'hF0, 'h3C, 1); step();
        chk("s2_acc1", last_acc, 1);
        drive(1, 1, 'hF0, 'h0F, 2); step();
        xchk("s2_r1", 'h30, 0, 1);
        drive(1, 2, 'hAA, 'hFF, 3); step();
        xchk("s2_r2", 'hFF, 0, 2);
        drive(1, 3, 'h10, 'h22, 4); step();
        xchk("s2_r3", 'h55, 0, 3);
        drive(0, 0, 0, 0, 0); step();
        xchk("s2_r4", 'h32, 0, 4);
        step();
        chk("s2_empty", rsp_valid, 0);

        // Overflow boundaries
        drive(1, 3, 'h7F, 'h01, 5); step();
        drive(1, 3, 'h80, 'h80, 6); step();
        xchk("s3_r1", 'h80, 1, 5);
        drive(1, 3, 'hFF, 'h01, 7); step();
        xchk("s3_r2", 'h00, 1, 6);
        drive(0, 0, 0, 0, 0); step();
        xchk("s3_r3", 'h00, 0, 7);
        step();
        chk("s3_ovf_count", ovf_count, 2);

        // Backpressure
        rsp_ready = 1'b0;
        n = 0;
        drive(1, $urandom_range(0, 3), $urandom_range(0, 255),
              $urandom_range(0, 255), 8);
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_acc) begin
                n++;
                drive(1, $urandom_range(0, 3), $urandom_range(0, 255),
                      $urandom_range(0, 255), 8 + n);
            end
        end
        chk("s4_accepts", n, 4);
        chk("s4_full_ready", req_ready, 0);
        chk("s4_head_tag", rsp_tag, 8);
        rsp_ready = 1'b1;
        step();
        chk("s4_pop_edge_acc", last_acc, 0);
        chk("s4_ready_after_pop", req_ready, 1);
        step();
        chk("s4_fifth_acc", last_acc, 1);
        drive(0, 0, 0, 0, 0);
        drain("s4", 20);

        // Reset with stage and FIFO occupied
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 3, 'h7F, i, i);
            step();
        end
        drive(0, 0, 0, 0, 0);
        chk("s5_busy_pre", busy, 1);
        chk("s5_full_pre", req_ready, 0);
        reset = 1'b1;
        drive(1, 0, 'hFF, 'hFF, 9);
        step();
        reset = 1'b0;
        chk("s5_busy", busy, 0);
        chk("s5_rsp_valid", rsp_valid, 0);
        chk("s5_req_ready", req_ready, 1);
        chk("s5_rsp_out", rsp_out, 0);
        rsp_ready = 1'b1;
        n_pop = 0;
        drive(1, 3, 'h05, 'h06, 'hA);
        step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step();
        chk("s5_single_rsp", n_pop, 1);

        // Random traffic against the reference model
        pend = 1'b0;
        op = 0; a = 0; b = 0; t = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!pend) begin
                op = $urandom_range(0, 3);
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
                t = $urandom_range(0, 15);
                pend = ($urandom_range(0, 3) != 0);
            end
            drive(pend, op, a, b, t);
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
            if (last_acc) pend = 1'b0;
        end
        drive(0, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        drain("s6", 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
